// File: rtl/stitch_pipe_ctrl.sv
// Valid/ready flow controller for a stitched pipeline: per-stage valid bits, load enables and
// bubble collapse. Defining STITCH_PIPE_CTRL_PERF_EN adds saturating transfer/stall counters.
module stitch_pipe_ctrl #(
    parameter  int STAGES = 2,
    parameter  int CNT_W  = 32,
    localparam int OCC_W  = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              flush,
    output logic [STAGES-1:0] stage_en,
    output logic [STAGES-1:0] stage_valid,
    output logic [OCC_W-1:0]  occupancy,
    output logic              idle,
    input  logic              perf_clr,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [STAGES:0]   rdy;
    logic [STAGES-1:0] up;

    always_comb begin
        rdy         = '0;
        up          = '0;
        stage_en    = '0;
        v_d         = v_q;
        occupancy   = '0;
        rdy[STAGES] = out_ready;
        // A stage can load when it is empty or its own contents are moving on.
        for (int i = STAGES - 1; i >= 0; i--) begin
            rdy[i] = !v_q[i] || rdy[i+1];
        end
        up[0] = in_valid;
        for (int i = 1; i < STAGES; i++) begin
            up[i] = v_q[i-1];
        end
        for (int i = 0; i < STAGES; i++) begin
            stage_en[i] = rdy[i] && up[i] && !flush;
            if (flush) begin
                v_d[i] = 1'b0;
            end else if (rdy[i]) begin
                v_d[i] = up[i];
            end
            occupancy = occupancy + OCC_W'(v_q[i]);
        end
        in_ready = rdy[0] && !flush;
        idle     = (occupancy == '0) && !in_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    assign stage_valid = v_q;
    assign out_valid   = v_q[STAGES-1] && !flush;

`ifdef STITCH_PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] xfer_q;
    logic [CNT_W-1:0] xfer_d;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] stall_d;

    // Clear wins over increment; both counters stick at all-ones.
    always_comb begin
        xfer_d  = xfer_q;
        stall_d = stall_q;
        if (perf_clr) begin
            xfer_d  = '0;
            stall_d = '0;
        end else begin
            if (out_valid && out_ready && (xfer_q != '1)) begin
                xfer_d = xfer_q + CNT_W'(1);
            end
            if (out_valid && !out_ready && (stall_q != '1)) begin
                stall_d = stall_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_q  <= '0;
            stall_q <= '0;
        end else begin
            xfer_q  <= xfer_d;
            stall_q <= stall_d;
        end
    end

    assign xfer_cnt  = xfer_q;
    assign stall_cnt = stall_q;
`else
    logic unused_perf_clr;
    assign unused_perf_clr = perf_clr;
    assign xfer_cnt        = '0;
    assign stall_cnt       = '0;
`endif

endmodule

// File: tb/tb_stitch_pipe_ctrl.sv
// Bench for stitch_pipe_ctrl: directed scenarios plus random traffic against a token-movement model.
module tb_stitch_pipe_ctrl;
    localparam int S  = 2;
    localparam int CW = 4;
    localparam int OW = $clog2(S + 1);

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic          flush;
    logic [S-1:0]  stage_en;
    logic [S-1:0]  stage_valid;
    logic [OW-1:0] occupancy;
    logic          idle;
    logic          perf_clr;
    logic [CW-1:0] xfer_cnt;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: which slots hold a token, plus counter values.
    logic [S-1:0] m_v;
    int           m_xfer;
    int           m_stall;

    stitch_pipe_ctrl #(.STAGES(S), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
        .stage_en(stage_en), .stage_valid(stage_valid), .occupancy(occupancy),
        .idle(idle), .perf_clr(perf_clr), .xfer_cnt(xfer_cnt), .stall_cnt(stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slot i can take a token when the output is draining or any slot at or after i is a hole.
    function automatic logic can_load(input int i);
        logic res;
        res = out_ready;
        for (int j = i; j < S; j++) if (!m_v[j]) res = 1'b1;
        return res;
    endfunction

    function automatic logic [S-1:0] m_en();
        logic [S-1:0] en;
        logic         upv;
        for (int i = 0; i < S; i++) begin
            upv   = (i == 0) ? in_valid : m_v[i-1];
            en[i] = can_load(i) && upv && !flush;
        end
        return en;
    endfunction

    function automatic logic m_in_ready();
        return can_load(0) && !flush;
    endfunction

    function automatic logic m_out_valid();
        return m_v[S-1] && !flush;
    endfunction

    function automatic int cnt_exp(input int val);
`ifdef STITCH_PIPE_CTRL_PERF_EN
        return val;
`else
        return 0 * val;
`endif
    endfunction

    task automatic reset_model();
        m_v     = '0;
        m_xfer  = 0;
        m_stall = 0;
    endtask

    // Advance one clock: tokens move where enabled, the last token leaves on an output transfer.
    task automatic tick();
        logic [S-1:0] en;
        logic [S-1:0] nv;
        logic         take;
        logic         leave;
        int           nx;
        int           ns;
        en   = m_en();
        take = m_out_valid() && out_ready;
        for (int i = 0; i < S; i++) begin
            if (i == S - 1) leave = take;
            else            leave = en[i+1];
            nv[i] = flush ? 1'b0 : (en[i] || (m_v[i] && !leave));
        end
        nx = m_xfer;
        ns = m_stall;
`ifdef STITCH_PIPE_CTRL_PERF_EN
        if (perf_clr) begin
            nx = 0;
            ns = 0;
        end else begin
            if (take && nx < (1 << CW) - 1) nx++;
            if (m_out_valid() && !out_ready && ns < (1 << CW) - 1) ns++;
        end
`endif
        @(posedge clk);
        m_v     = nv;
        m_xfer  = nx;
        m_stall = ns;
        @(negedge clk);
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic fl, input logic clr);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        perf_clr  = clr;
        #1;
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (occupancy !== OW'(0)) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", idle); end
        checks++; if (stage_en !== 2'b00) begin errors++; $display("FAIL reset_stage_en: got %b want 00", stage_en); end
        checks++; if (xfer_cnt !== CW'(0) || stall_cnt !== CW'(0)) begin errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", xfer_cnt, stall_cnt); end
    endtask

    task automatic test_single();
        drive(1, 1, 0, 0);
        checks++; if (stage_en !== 2'b01) begin errors++; $display("FAIL single_en0: got %b want 01", stage_en); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_rdy: got %b want 1", in_ready); end
        tick();
        drive(0, 1, 0, 0);
        checks++; if (stage_en !== 2'b10) begin errors++; $display("FAIL single_en1: got %b want 10", stage_en); end
        checks++; if (occupancy !== OW'(1) || out_valid !== 1'b0) begin errors++; $display("FAIL single_c1: got occ %0d ov %b want 1 0", occupancy, out_valid); end
        tick();
        checks++; if (occupancy !== OW'(1) || out_valid !== 1'b1) begin errors++; $display("FAIL single_c2: got occ %0d ov %b want 1 1", occupancy, out_valid); end
        checks++; if (stage_en !== 2'b00) begin errors++; $display("FAIL single_en2: got %b want 00", stage_en); end
        tick();
        checks++; if (occupancy !== OW'(0) || out_valid !== 1'b0) begin errors++; $display("FAIL single_c3: got occ %0d ov %b want 0 0", occupancy, out_valid); end
    endtask

    task automatic test_stream();
        int n = 0;
        drive(0, 1, 0, 1);
        tick();
        for (int k = 0; k < 14; k++) begin
            drive(k < 10, 1, 0, 0);
            checks++; if (out_valid !== (k >= 2 && k < 12)) begin errors++; $display("FAIL stream_ov[%0d]: got %b want %b", k, out_valid, (k >= 2 && k < 12)); end
            if (out_valid === 1'b1) n++;
            tick();
        end
        checks++; if (n != 10) begin errors++; $display("FAIL stream_count: got %0d want 10", n); end
        checks++; if (xfer_cnt !== CW'(cnt_exp(10))) begin errors++; $display("FAIL stream_xfer_cnt: got %0d want %0d", xfer_cnt, cnt_exp(10)); end
    endtask

    task automatic test_backpressure();
        drive(1, 1, 0, 1);
        tick();
        drive(1, 1, 0, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 0, 0);
            checks++; if (in_ready !== 1'b0 || stage_en !== 2'b00) begin errors++; $display("FAIL bp_hold[%0d]: got rdy %b en %b want 0 00", k, in_ready, stage_en); end
            checks++; if (occupancy !== OW'(2)) begin errors++; $display("FAIL bp_occ[%0d]: got %0d want 2", k, occupancy); end
            tick();
        end
        checks++; if (stall_cnt !== CW'(cnt_exp(5))) begin errors++; $display("FAIL bp_stall_cnt: got %0d want %0d", stall_cnt, cnt_exp(5)); end
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0, 0);
            checks++; if (out_valid !== (k < 2)) begin errors++; $display("FAIL bp_drain[%0d]: got %b want %b", k, out_valid, (k < 2)); end
            tick();
        end
    endtask

    task automatic test_bubble();
        drive(1, 1, 0, 0);
        tick();
        drive(0, 1, 0, 0);
        tick();
        drive(1, 0, 0, 0);
        checks++; if (stage_valid !== 2'b10) begin errors++; $display("FAIL bubble_pre: got %b want 10", stage_valid); end
        checks++; if (in_ready !== 1'b1 || stage_en !== 2'b01) begin errors++; $display("FAIL bubble_en: got rdy %b en %b want 1 01", in_ready, stage_en); end
        tick();
        checks++; if (stage_valid !== 2'b11) begin errors++; $display("FAIL bubble_post: got %b want 11", stage_valid); end
    endtask

    task automatic test_flush();
        drive(1, 1, 1, 0);
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || stage_en !== 2'b00) begin errors++; $display("FAIL flush_cycle: got rdy %b ov %b en %b want 0 0 00", in_ready, out_valid, stage_en); end
        tick();
        drive(0, 0, 0, 0);
        checks++; if (stage_valid !== 2'b00) begin errors++; $display("FAIL flush_after: got %b want 00", stage_valid); end
        checks++; if (xfer_cnt !== CW'(m_xfer) || stall_cnt !== CW'(m_stall)) begin errors++; $display("FAIL flush_cnt: got %0d/%0d want %0d/%0d", xfer_cnt, stall_cnt, m_xfer, m_stall); end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 0, 0);
            tick();
        end
        drive(1, 1, 0, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre: got %b want 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        reset_model();
        checks++; if (out_valid !== 1'b0 || stage_valid !== 2'b00) begin errors++; $display("FAIL arst_now: got ov %b v %b want 0 00", out_valid, stage_valid); end
        checks++; if (xfer_cnt !== CW'(0) || stall_cnt !== CW'(0)) begin errors++; $display("FAIL arst_cnt: got %0d/%0d want 0/0", xfer_cnt, stall_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 0, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 500; k++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0);
            checks++; if (in_ready !== m_in_ready()) begin errors++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", k, in_ready, m_in_ready()); end
            checks++; if (out_valid !== m_out_valid()) begin errors++; $display("FAIL rnd_out_valid[%0d]: got %b want %b", k, out_valid, m_out_valid()); end
            checks++; if (stage_en !== m_en()) begin errors++; $display("FAIL rnd_stage_en[%0d]: got %b want %b", k, stage_en, m_en()); end
            checks++; if (stage_valid !== m_v) begin errors++; $display("FAIL rnd_stage_valid[%0d]: got %b want %b", k, stage_valid, m_v); end
            checks++; if (occupancy !== OW'($countones(m_v))) begin errors++; $display("FAIL rnd_occ[%0d]: got %0d want %0d", k, occupancy, $countones(m_v)); end
            checks++; if (idle !== ($countones(m_v) == 0 && !in_valid)) begin errors++; $display("FAIL rnd_idle[%0d]: got %b", k, idle); end
            checks++; if (xfer_cnt !== CW'(m_xfer)) begin errors++; $display("FAIL rnd_xfer[%0d]: got %0d want %0d", k, xfer_cnt, m_xfer); end
            checks++; if (stall_cnt !== CW'(m_stall)) begin errors++; $display("FAIL rnd_stall[%0d]: got %0d want %0d", k, stall_cnt, m_stall); end
            tick();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        perf_clr  = 1'b0;
        reset_model();
        @(negedge clk);
        @(negedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 0, 0);
        test_reset();
        tick();
        test_single();
        test_stream();
        test_backpressure();
        test_bubble();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stitch_pipe_ctrl.md
# stitch_pipe_ctrl

Valid/ready flow controller for a stitched, pipelined datapath. Each stage-output register `pN` gets a valid bit and a load enable, so back-pressure stalls the pipeline and bubbles collapse. Sits beside the generated stage modules and their `pN` registers inside the top-level stitch wrapper. It drives only the register enables and valid bits; datapath logic is untouched.

## Interface
- `STAGES`, default 2: number of pipeline registers (`p1`..`pSTAGES`); legal range 1..16.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `in_valid`  in  1  upstream offers a datum to stage 0.
- `in_ready`  out  1  stage 0 can accept; transfer when `in_valid && in_ready`.
- `out_valid`  out  1  last register holds a valid result.
- `out_ready`  in  1  downstream accepts; transfer when `out_valid && out_ready`.
- `flush`  in  1  synchronous discard of all in-flight data.
- `stage_en`  out  STAGES  load enable for register `p(i+1)`.
- `stage_valid`  out  STAGES  valid bit of register `p(i+1)`.
- `occupancy`  out  $clog2(STAGES+1)  number of set valid bits.
- `idle`  out  1  `occupancy==0 && !in_valid`.
- `perf_clr`  in  1  synchronous clear of the performance counters.
- `xfer_cnt`  out  CNT_W  count of output transfers.
- `stall_cnt`  out  CNT_W  count of stalled output cycles.

## Operation
- State: `v[STAGES-1:0]`, one flop per stage, reset to 0.
- Ready chain: `r[STAGES] = out_ready` and `r[i] = !v[i] || r[i+1]`. This is a combinational chain, STAGES deep.
- Upstream valid: `u[0] = in_valid` and `u[i] = v[i-1]`.
- Per stage:
  - `stage_en[i] = r[i] && u[i] && !flush`.
  - Next `v[i]` is `u[i]` when `r[i]`, otherwise it holds.
  - A bubble loads only a valid clear, never a data enable.
- Outputs:
  - `in_ready = r[0] && !flush`.
  - `out_valid = v[STAGES-1] && !flush`.
  - `stage_valid = v`.
- Flush:
  - While asserted, all `v` clear on the next edge and all `stage_en` are 0.
  - No input or output transfer occurs in a flush cycle.
  - Flush has priority over every other event.
- Simultaneous output take and input accept on a full pipe: every stage advances, occupancy is unchanged, throughput is one datum per cycle.
- Stall: with `out_ready=0` and the pipe full, all `stage_en=0` and `in_ready=0`. Data holds indefinitely.
- Partial stall: a bubble at stage k lets stages `0..k` advance while stages `>k` hold, which collapses the bubble.
- Reset mid-operation: all valid bits clear immediately and in-flight data is lost. Register contents are don't-care.

## Timing
- Reset values:
  - `v=0`, so `out_valid=0`, `stage_valid=0`, `occupancy=0`, `stage_en=0`.
  - `in_ready=1` (unless `flush`).
  - `idle = !in_valid`.
  - Counters are 0.
- Latency: a datum accepted at edge t into an empty pipe gives `out_valid=1` in the cycle after edge t+STAGES-1. That is STAGES cycles, matching the stitched pipeline depth.
- Throughput: 1 per cycle when `out_ready` is held high.
- `in_ready` depends combinationally on `out_ready` and `flush`. `out_valid` depends only on flops and `flush`.

## Configuration
- `STITCH_PIPE_CTRL_PERF_EN` defined:
  - `xfer_cnt` increments on each `out_valid && out_ready`.
  - `stall_cnt` increments on each `out_valid && !out_ready`.
  - Both saturate at all-ones.
  - `perf_clr` zeroes both on the next edge and takes priority over increment.
- Macro undefined:
  - Counter ports remain present, tied to 0.
  - `perf_clr` is ignored.
  - No counter flops are generated.

## Test plan
- Reset then idle, STAGES=2, hold `in_valid=0`: `in_ready=1`, `out_valid=0`, `occupancy=0`, `idle=1`, `stage_en=2'b00`.
- Single datum: pulse `in_valid` for 1 cycle with `out_ready=1`.
  - `stage_en` goes 01 then 10.
  - `out_valid` is high exactly 2 cycles after acceptance, for 1 cycle.
  - `occupancy` reads 1, 1, 0.
- Streaming: `in_valid=1` and `out_ready=1` for 10 cycles.
  - 10 outputs, back to back, starting at cycle 2.
  - `xfer_cnt=10` with PERF_EN.
- Back-pressure: fill the pipe, then `out_ready=0` for 5 cycles.
  - `in_ready=0`, `stage_en=0`, `occupancy=2`.
  - `stall_cnt=5`, then data drains in order.
- Bubble collapse: valid pattern `v=2'b10` with `out_ready=0` and `in_valid=1`.
  - `in_ready=1`, `stage_en=2'b01`, next `v=2'b11`.
- Flush: assert `flush` with `v=2'b11`, `in_valid=1`, `out_ready=1`.
  - That cycle: `in_ready=0`, `out_valid=0`, no counter increment.
  - Next cycle: `v=0`.
  - Assert `rst_n` low mid-stream: `out_valid` falls asynchronously.
